// File: rtl/pipe_skid_stage.sv
// Pipeline-boundary register with valid/ready handshake, a 2-entry skid buffer, flush and bubble emission.
// Latency is 1 cycle when empty, with a sustained 1 txn/cycle; in_ready drops only when both entries are held.
module pipe_skid_stage #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] BUBBLE    = '0,
    parameter logic [WIDTH-1:0] KEEP_MASK = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_nop,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] r_last_out;
    logic             w_push;
    logic             w_pop;

    // Handshake derives only from registered state, so there is no in->out combinational path.
    assign in_ready  = (r_state != FULL) && !reset;
    assign out_valid = (r_state != EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_main     <= BUBBLE;
            r_skid     <= BUBBLE;
            r_last_out <= BUBBLE;
        end else if (flush) begin
            r_state <= EMPTY;
        end else begin
            if (w_pop) begin
                r_last_out <= r_main;
            end
            unique case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_state <= ONE;
                        r_main  <= in_data;
                    end
                end
                ONE: begin
                    case ({w_push, w_pop})
                        2'b11:   r_main <= in_data;
                        2'b10: begin
                            r_state <= FULL;
                            r_skid  <= in_data;
                        end
                        2'b01:   r_state <= EMPTY;
                        default: r_state <= ONE;
                    endcase
                end
                FULL: begin
                    if (w_pop) begin
                        r_state <= ONE;
                        r_main  <= r_skid;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    // Bubble keeps the masked fields (e.g. pc) of the last instruction handed downstream.
    assign out_data  = out_valid ? r_main : ((r_last_out & KEEP_MASK) | (BUBBLE & ~KEEP_MASK));
    assign out_nop   = !out_valid;
    assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue-based reference model compared every cycle, plus directed literal checks.
module tb_pipe_skid_stage;

    localparam int          W  = 64;
    localparam logic [W-1:0] KM = 64'hFFFF;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         flush     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data   = '0;

    logic         in_ready_a, out_valid_a, out_nop_a;
    logic [W-1:0] out_data_a;
    logic [1:0]   occ_a;
    logic         in_ready_b, out_valid_b, out_nop_b;
    logic [W-1:0] out_data_b;
    logic [1:0]   occ_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [W-1:0] mq[$];
    logic [W-1:0] m_last = '0;

    pipe_skid_stage #(.WIDTH(W)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_nop(out_nop_a), .occupancy(occ_a)
    );

    pipe_skid_stage #(.WIDTH(W), .BUBBLE('0), .KEEP_MASK(KM)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_nop(out_nop_b), .occupancy(occ_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    // Reference: a bounded FIFO of at most two entries plus the last value handed downstream.
    always @(posedge clk) begin : model
        int sz;
        bit push, pop;
        sz   = mq.size();
        push = in_valid && (sz < 2) && !reset;
        pop  = (sz > 0) && out_ready;
        if (reset) begin
            mq.delete();
            m_last = '0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (pop)  m_last = mq.pop_front();
            if (push) mq.push_back(in_data);
        end
    end

    always @(negedge clk) begin : compare
        int           sz;
        logic [W-1:0] ed_a, ed_b;
        if (chk_en) begin
            sz   = mq.size();
            ed_a = (sz > 0) ? mq[0] : '0;
            ed_b = (sz > 0) ? mq[0] : (m_last & KM);
            chk("m_in_ready_a",  {63'd0, in_ready_a},  {63'd0, (sz < 2) && !reset});
            chk("m_out_valid_a", {63'd0, out_valid_a}, {63'd0, sz > 0});
            chk("m_out_nop_a",   {63'd0, out_nop_a},   {63'd0, sz == 0});
            chk("m_occ_a",       {62'd0, occ_a},       64'(sz));
            chk("m_out_data_a",  out_data_a,           ed_a);
            chk("m_in_ready_b",  {63'd0, in_ready_b},  {63'd0, (sz < 2) && !reset});
            chk("m_out_valid_b", {63'd0, out_valid_b}, {63'd0, sz > 0});
            chk("m_occ_b",       {62'd0, occ_b},       64'(sz));
            chk("m_out_data_b",  out_data_b,           ed_b);
        end
    end

    initial begin
        // Reset
        @(negedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_low", {63'd0, in_ready_a}, 64'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("rst_out_data",  out_data_a, 64'd0);
        chk("rst_out_nop",   {63'd0, out_nop_a}, 64'd1);
        chk("rst_in_ready",  {63'd0, in_ready_a}, 64'd1);
        chk("rst_occ",       {62'd0, occ_a}, 64'd0);

        // Streaming 1..8 with out_ready high
        #1;
        in_valid = 1'b1; out_ready = 1'b1; in_data = 64'd1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("stream_data",  out_data_a, 64'(k));
            chk("stream_valid", {63'd0, out_valid_a}, 64'd1);
            #1;
            if (k < 8) in_data = 64'(k + 1);
            else       in_valid = 1'b0;
        end
        @(negedge clk);
        chk("stream_end_valid", {63'd0, out_valid_a}, 64'd0);
        chk("stream_end_keep",  out_data_b, 64'd8);

        // Fill both entries under back-pressure, then drain
        #1;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA0A0_0000_0000_1111;
        @(negedge clk);
        #1 in_data = 64'hB0B0_0000_0000_2222;
        @(negedge clk);
        chk("full_occ",      {62'd0, occ_a}, 64'd2);
        chk("full_in_ready", {63'd0, in_ready_a}, 64'd0);
        chk("full_hold_A",   out_data_a, 64'hA0A0_0000_0000_1111);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("full_still_A",  out_data_a, 64'hA0A0_0000_0000_1111);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("drain_B",        out_data_a, 64'hB0B0_0000_0000_2222);
        chk("drain_in_ready", {63'd0, in_ready_a}, 64'd1);
        @(negedge clk);
        chk("drain_empty",    {63'd0, out_valid_a}, 64'd0);

        // Flush while full with a concurrent push
        #1;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h0000_0000_0000_3333;
        @(negedge clk);
        #1 in_data = 64'h0000_0000_0000_4444;
        @(negedge clk);
        chk("pre_flush_occ", {62'd0, occ_a}, 64'd2);
        #1 flush = 1'b1; in_data = 64'h0000_0000_0000_5555;
        @(negedge clk);
        chk("flush_valid", {63'd0, out_valid_a}, 64'd0);
        chk("flush_occ",   {62'd0, occ_a}, 64'd0);
        #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_no_C",    {63'd0, out_valid_a}, 64'd0);
        chk("flush_keep_last", out_data_b, 64'h0000_0000_0000_2222);

        // Bubble keeps masked low bits of the last popped payload
        #1 in_valid = 1'b1; in_data = 64'h1234_0000_ABCD;
        @(negedge clk);
        chk("keep_valid_data", out_data_b, 64'h1234_0000_ABCD);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("keep_bubble", out_data_b, 64'h0000_0000_ABCD);
        chk("keep_nop",    {63'd0, out_nop_b}, 64'd1);
        chk("nokeep_bubble", out_data_a, 64'd0);

        // Randomized traffic with varying back-pressure, occasional flush and reset
        for (int i = 0; i < 10000; i++) begin
            int rdy_pct;
            @(negedge clk);
            #1;
            rdy_pct   = ((i / 1000) % 4) * 30 + 5;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            in_data   = {$urandom, $urandom};
            flush     = ($urandom_range(0, 63) == 0);
            reset     = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        #1 reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("final_drained", {62'd0, occ_a}, 64'd0);
        #1 chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
